// File: rtl/aging_chk_pkg.sv
// Shared types and constants for the aging-experiment response checker.
package aging_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // c7552 has 108 primary outputs
  localparam int unsigned C7552_OUTPUTS = 108;

  localparam logic [1:0] MISR_TAPS = 2'b11;
  localparam logic [C7552_OUTPUTS-1:0] MISR_POLY_DEFAULT =
    {{(C7552_OUTPUTS-2){1'b0}}, MISR_TAPS};

endpackage

// File: rtl/aging_resp_checker_if.sv
// Response stream plus golden-memory read port between the DUT bus and the checker.
interface aging_resp_checker_if
  import aging_chk_pkg::*;
#(
  parameter int unsigned VEC_WIDTH = C7552_OUTPUTS,
  parameter int unsigned IDX_W     = 16
);

  logic                 resp_valid;
  logic                 resp_ready;
  logic [VEC_WIDTH-1:0] resp_vec;
  logic [IDX_W-1:0]     exp_addr;
  logic [VEC_WIDTH-1:0] exp_data;

  modport slave (
    input  resp_valid, resp_vec, exp_data,
    output resp_ready, exp_addr
  );

  modport master (
    output resp_valid, resp_vec, exp_data,
    input  resp_ready, exp_addr
  );

endinterface

// File: rtl/aging_resp_checker_misr.sv
// Multiple-input signature register; clr has priority over en.
module aging_misr
  import aging_chk_pkg::*;
#(
  parameter int unsigned          VEC_WIDTH = C7552_OUTPUTS,
  parameter logic [VEC_WIDTH-1:0] MISR_POLY = VEC_WIDTH'(MISR_POLY_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [VEC_WIDTH-1:0] din,
  output logic [VEC_WIDTH-1:0] sig
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[VEC_WIDTH-2:0], 1'b0} ^ (sig[VEC_WIDTH-1] ? MISR_POLY : '0) ^ din;
    end
  end

endmodule

// File: rtl/aging_resp_checker.sv
// Compares one DUT output vector per cycle against a synchronous golden memory
// and accumulates mismatch count, first failing index, bit mask and MISR signature.
module aging_resp_checker
  import aging_chk_pkg::*;
#(
  parameter int unsigned          VEC_WIDTH  = C7552_OUTPUTS,
  parameter int unsigned          VEC_LENGTH = 7,
  parameter int unsigned          IDX_W      = 16,
  parameter int unsigned          CNT_W      = 16,
  parameter logic [VEC_WIDTH-1:0] MISR_POLY  = VEC_WIDTH'(MISR_POLY_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  aging_resp_checker_if.slave  rif,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 first_fail_valid,
  output logic [IDX_W-1:0]     first_fail_idx,
  output logic [VEC_WIDTH-1:0] bit_fail_mask,
  output logic [VEC_WIDTH-1:0] signature
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LENGTH - 1);

  state_t               state, state_n;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     addr_q;
  logic                 ready_q;
  logic                 s1_valid;
  logic [VEC_WIDTH-1:0] s1_resp;
  logic [IDX_W-1:0]     s1_idx;
  logic [CNT_W-1:0]     err_cnt_n;
  logic                 accept_c;
  logic                 launch_c;
  logic                 mismatch_c;
  logic [VEC_WIDTH-1:0] diff_c;

  assign accept_c       = rif.resp_valid && ready_q;
  assign launch_c       = start && ((state == IDLE) || (state == DONE));
  assign diff_c         = s1_resp ^ rif.exp_data;
  assign mismatch_c     = s1_valid && (diff_c != '0);
  assign rif.resp_ready = ready_q;
  // Address is presented in the accept cycle so golden data lines up with stage 1
  assign rif.exp_addr   = accept_c ? idx : addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start) state_n = RUN;
      RUN:        if (accept_c && (idx == LAST_IDX)) state_n = DRAIN;
      DRAIN:      state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  always_comb begin
    err_cnt_n = err_cnt;
    if (launch_c) begin
      err_cnt_n = '0;
    end else if (mismatch_c && (err_cnt != '1)) begin
      err_cnt_n = err_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q          <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_cnt          <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      bit_fail_mask    <= '0;
      idx              <= '0;
      addr_q           <= '0;
      s1_valid         <= 1'b0;
      s1_resp          <= '0;
      s1_idx           <= '0;
    end else begin
      ready_q  <= (state_n == RUN);
      busy     <= (state_n == RUN) || (state_n == DRAIN);
      done     <= (state_n == DONE);
      // err_cnt_n already includes the final compare retired on entry to DONE
      pass     <= (state_n == DONE) && (err_cnt_n == '0);
      err_cnt  <= err_cnt_n;
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_resp <= rif.resp_vec;
        s1_idx  <= idx;
        addr_q  <= idx;
        idx     <= idx + IDX_W'(1);
      end
      if (launch_c) begin
        idx              <= '0;
        first_fail_valid <= 1'b0;
        first_fail_idx   <= '0;
        bit_fail_mask    <= '0;
      end else if (mismatch_c) begin
        bit_fail_mask <= bit_fail_mask | diff_c;
        if (!first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_idx   <= s1_idx;
        end
      end
    end
  end

  aging_misr #(
    .VEC_WIDTH (VEC_WIDTH),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (launch_c),
    .en    (accept_c),
    .din   (rif.resp_vec),
    .sig   (signature)
  );

endmodule

// File: tb/tb_aging_resp_checker.sv
// Bench for aging_resp_checker: table vectors, hand sequences and random runs.
module tb_aging_resp_checker;

  localparam int unsigned W  = 8;
  localparam int unsigned LA = 4;
  localparam int unsigned LB = 5;
  localparam logic [W-1:0] POLY = 8'h03;

  typedef struct packed {
    logic [31:0] resp;
    logic [15:0] gaps;
    logic [15:0] err;
    logic        ffv;
    logic [15:0] ffi;
    logic [7:0]  mask;
    logic        exp_pass;
  } tv_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic        a_busy, a_done, a_pass, a_ffv;
  logic [15:0] a_err, a_ffi;
  logic [7:0]  a_mask, a_sig;
  logic        b_busy, b_done, b_pass, b_ffv;
  logic [1:0]  b_err;
  logic [15:0] b_ffi;
  logic [7:0]  b_mask, b_sig;

  logic [7:0] gmem_a [16];
  logic [7:0] gmem_b [16];
  logic [7:0] rv     [16];
  int         gap    [16];

  int n_checks = 0;
  int n_fail   = 0;

  aging_resp_checker_if #(.VEC_WIDTH(W), .IDX_W(16)) ra ();
  aging_resp_checker_if #(.VEC_WIDTH(W), .IDX_W(16)) rb ();

  aging_resp_checker #(
    .VEC_WIDTH(W), .VEC_LENGTH(LA), .IDX_W(16), .CNT_W(16), .MISR_POLY(POLY)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .rif(ra),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_cnt(a_err),
    .first_fail_valid(a_ffv), .first_fail_idx(a_ffi),
    .bit_fail_mask(a_mask), .signature(a_sig)
  );

  aging_resp_checker #(
    .VEC_WIDTH(W), .VEC_LENGTH(LB), .IDX_W(16), .CNT_W(2), .MISR_POLY(POLY)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .rif(rb),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_cnt(b_err),
    .first_fail_valid(b_ffv), .first_fail_idx(b_ffi),
    .bit_fail_mask(b_mask), .signature(b_sig)
  );

  always #5 clk = ~clk;

  // Synchronous golden memories: data one cycle after address
  always @(posedge clk) begin
    ra.exp_data <= gmem_a[ra.exp_addr[3:0]];
    rb.exp_data <= gmem_b[rb.exp_addr[3:0]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] d);
    return (s << 1) ^ (s[7] ? POLY : 8'h00) ^ d;
  endfunction

  task automatic pulse_start_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_busy"},  64'(a_busy), 64'd0);
    chk({tag, "_done"},  64'(a_done), 64'd0);
    chk({tag, "_pass"},  64'(a_pass), 64'd0);
    chk({tag, "_err"},   64'(a_err),  64'd0);
    chk({tag, "_ffv"},   64'(a_ffv),  64'd0);
    chk({tag, "_ffi"},   64'(a_ffi),  64'd0);
    chk({tag, "_mask"},  64'(a_mask), 64'd0);
    chk({tag, "_sig"},   64'(a_sig),  64'd0);
    chk({tag, "_ready"}, 64'(ra.resp_ready), 64'd0);
    chk({tag, "_addr"},  64'(ra.exp_addr),   64'd0);
  endtask

  // Full run on dut_a using rv[]/gap[]; compares results with the given expectations
  task automatic run_a(input string tag, input logic [15:0] e_err, input logic e_ffv,
                       input logic [15:0] e_ffi, input logic [7:0] e_mask,
                       input logic e_pass, input logic [7:0] e_sig);
    pulse_start_a();
    chk({tag, "_busy_run"}, 64'(a_busy), 64'd1);
    chk({tag, "_ready"},    64'(ra.resp_ready), 64'd1);
    for (int k = 0; k < int'(LA); k++) begin
      for (int g = 0; g < gap[k]; g++) begin
        ra.resp_valid = 1'b0;
        #1;
        if (k > 0) chk({tag, "_addr_hold"}, 64'(ra.exp_addr), 64'(k - 1));
        @(negedge clk);
      end
      ra.resp_valid = 1'b1;
      ra.resp_vec   = rv[k];
      #1;
      chk({tag, "_addr"}, 64'(ra.exp_addr), 64'(k));
      @(negedge clk);
    end
    ra.resp_valid = 1'b0;
    chk({tag, "_drain_done"},  64'(a_done), 64'd0);
    chk({tag, "_drain_ready"}, 64'(ra.resp_ready), 64'd0);
    chk({tag, "_drain_busy"},  64'(a_busy), 64'd1);
    @(negedge clk);
    chk({tag, "_done"}, 64'(a_done), 64'd1);
    chk({tag, "_busy"}, 64'(a_busy), 64'd0);
    chk({tag, "_pass"}, 64'(a_pass), 64'(e_pass));
    chk({tag, "_err"},  64'(a_err),  64'(e_err));
    chk({tag, "_ffv"},  64'(a_ffv),  64'(e_ffv));
    if (e_ffv) chk({tag, "_ffi"}, 64'(a_ffi), 64'(e_ffi));
    chk({tag, "_mask"}, 64'(a_mask), 64'(e_mask));
    chk({tag, "_sig"},  64'(a_sig),  64'(e_sig));
  endtask

  initial begin
    tv_t tbl [6];
    logic [7:0] sb;

    tbl[0] = '{resp:32'h44332211, gaps:16'h0000, err:16'd0, ffv:1'b0, ffi:16'd0, mask:8'h00, exp_pass:1'b1};
    tbl[1] = '{resp:32'hC4332311, gaps:16'h0000, err:16'd2, ffv:1'b1, ffi:16'd1, mask:8'h81, exp_pass:1'b0};
    tbl[2] = '{resp:32'h44332211, gaps:16'h1020, err:16'd0, ffv:1'b0, ffi:16'd0, mask:8'h00, exp_pass:1'b1};
    tbl[3] = '{resp:32'hC4332311, gaps:16'h0301, err:16'd2, ffv:1'b1, ffi:16'd1, mask:8'h81, exp_pass:1'b0};
    tbl[4] = '{resp:32'hBBCCDDEE, gaps:16'h0000, err:16'd4, ffv:1'b1, ffi:16'd0, mask:8'hFF, exp_pass:1'b0};
    tbl[5] = '{resp:32'h45332211, gaps:16'h2000, err:16'd1, ffv:1'b1, ffi:16'd3, mask:8'h01, exp_pass:1'b0};

    ra.resp_valid = 1'b0; ra.resp_vec = '0;
    rb.resp_valid = 1'b0; rb.resp_vec = '0;
    for (int k = 0; k < 16; k++) begin
      gmem_a[k] = '0; gmem_b[k] = 8'(k + 1); rv[k] = '0; gap[k] = 0;
    end
    gmem_a[0] = 8'h11; gmem_a[1] = 8'h22; gmem_a[2] = 8'h33; gmem_a[3] = 8'h44;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_a("rst");
    chk("rst_b_ready", 64'(rb.resp_ready), 64'd0);
    chk("rst_b_err",   64'(b_err), 64'd0);
    rst_n = 1'b1;

    // Table-driven runs
    for (int t = 0; t < 6; t++) begin
      logic [7:0] s;
      s = '0;
      for (int k = 0; k < int'(LA); k++) begin
        rv[k]  = tbl[t].resp[8*k +: 8];
        gap[k] = int'(tbl[t].gaps[4*k +: 4]);
        s      = misr_step(s, rv[k]);
      end
      run_a($sformatf("tv%0d", t), tbl[t].err, tbl[t].ffv, tbl[t].ffi,
            tbl[t].mask, tbl[t].exp_pass, s);
    end

    // MISR step-by-step
    pulse_start_a();
    ra.resp_valid = 1'b1; ra.resp_vec = 8'h80;
    @(negedge clk); chk("misr_sig0", 64'(a_sig), 64'h80);
    ra.resp_vec = 8'h01;
    @(negedge clk); chk("misr_sig1", 64'(a_sig), 64'h02);
    ra.resp_vec = 8'h33; @(negedge clk);
    ra.resp_vec = 8'h44; @(negedge clk);
    ra.resp_valid = 1'b0;
    @(negedge clk);
    chk("misr_done", 64'(a_done), 64'd1);
    chk("misr_err",  64'(a_err),  64'd2);
    chk("misr_ffi",  64'(a_ffi),  64'd0);
    chk("misr_mask", 64'(a_mask), 64'hB3);

    // Reset in the middle of a run, then a clean rerun
    pulse_start_a();
    ra.resp_valid = 1'b1; ra.resp_vec = 8'h11; @(negedge clk);
    ra.resp_vec = 8'h23; @(negedge clk);
    ra.resp_valid = 1'b0;
    chk("mid_busy", 64'(a_busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_a("midrst");
    rst_n = 1'b1;
    for (int k = 0; k < int'(LA); k++) begin
      rv[k] = gmem_a[k]; gap[k] = 0;
    end
    run_a("rerun", 16'd0, 1'b0, 16'd0, 8'h00, 1'b1,
          misr_step(misr_step(misr_step(misr_step(8'h00, 8'h11), 8'h22), 8'h33), 8'h44));

    // Saturating 2-bit counter, all vectors wrong
    sb = '0;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int k = 0; k < int'(LB); k++) begin
      rb.resp_valid = 1'b1;
      rb.resp_vec   = ~gmem_b[k];
      sb            = misr_step(sb, ~gmem_b[k]);
      @(negedge clk);
    end
    rb.resp_valid = 1'b0;
    chk("sat_drain_err",   64'(b_err), 64'd3);
    chk("sat_drain_ready", 64'(rb.resp_ready), 64'd0);
    @(negedge clk);
    chk("sat_done", 64'(b_done), 64'd1);
    chk("sat_err",  64'(b_err),  64'd3);
    chk("sat_ffv",  64'(b_ffv),  64'd1);
    chk("sat_ffi",  64'(b_ffi),  64'd0);
    chk("sat_pass", 64'(b_pass), 64'd0);
    chk("sat_mask", 64'(b_mask), 64'hFF);
    chk("sat_sig",  64'(b_sig),  64'(sb));
    chk("sat_busy", 64'(b_busy), 64'd0);

    // Random runs against a reference model
    for (int r = 0; r < 20; r++) begin
      logic [15:0] e, fi;
      logic        f;
      logic [7:0]  m, s, d;
      e = '0; fi = '0; f = 1'b0; m = '0; s = '0;
      for (int k = 0; k < int'(LA); k++) begin
        gmem_a[k] = 8'($urandom);
        rv[k]     = ($urandom_range(0, 2) == 0) ? gmem_a[k] ^ 8'($urandom_range(1, 255)) : gmem_a[k];
        gap[k]    = int'($urandom_range(0, 2));
        d         = rv[k] ^ gmem_a[k];
        if (d != '0) begin
          e++;
          m |= d;
          if (!f) begin f = 1'b1; fi = 16'(k); end
        end
        s = misr_step(s, rv[k]);
      end
      run_a($sformatf("rnd%0d", r), e, f, fi, m, (e == '0), s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
